ssd_scan: RTL

SSD_SCAN -- requirements
Module: ssd_scan

---
 rtl/ssd_scan.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ssd_scan.sv
// ssd_scan -- four-digit multiplexed seven-segment display driver.
//
// Purpose:
//   Scans four BCD digits onto a common-anode style display. New digit data
//   lands in a shadow buffer and is copied into the display buffer only at a
//   frame boundary (scan select stepping 3 -> 0), so a frame never shows a mix
//   of old and new digits. Supports leading-zero blanking, per-digit decimal
//   points, a dash pattern for non-BCD nibbles and a 1 Hz blink.
//
// Ports:
//   clk        in   1  clock, all state on rising edge
//   rst_n      in   1  synchronous active-low reset
//   clk_ctl    in   2  scan select from the divider (0..3 = digit 0..3)
//   tick_1hz   in   1  blink phase level
//   load       in   1  strobe: capture digits_in/dp_in into shadow buffer
//   digits_in  in  16  four BCD nibbles, [3:0] = digit 0 (rightmost)
//   dp_in      in   4  decimal point request per digit, active-high
//   blank_lz   in   1  leading-zero blanking enable
//   blink_en   in   1  blink enable
//   ssd_ctl    out  4  digit enables, active-low
//   ssd_out    out  8  segments {a,b,c,d,e,f,g,dp}, active-low
//   pending    out  1  shadow holds data not yet committed
//   commit     out  1  one-cycle pulse when the display buffer updates
module ssd_scan #(
    parameter logic [7:0] INVALID_PAT = 8'b1111_1101
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  clk_ctl,
    input  logic        tick_1hz,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    input  logic        blink_en,
    output logic [3:0]  ssd_ctl,
    output logic [7:0]  ssd_out,
    output logic        pending,
    output logic        commit
);

    // clk_ctl comes from another timing source; sample it once and then
    // work only from the registered copies.
    logic [1:0]  ctl_q;
    logic [1:0]  ctl_p;
    logic        tick_q;

    logic [15:0] shadow_digits_reg;
    logic [3:0]  shadow_dp_reg;
    logic [15:0] disp_digits_reg;
    logic [3:0]  disp_dp_reg;
    logic        pending_reg;
    logic        commit_reg;
    logic [3:0]  ssd_ctl_reg;
    logic [7:0]  ssd_out_reg;

    logic [3:0]  ssd_ctl_next;
    logic [7:0]  ssd_out_next;
    logic [3:0]  blank_digit;
    logic [3:0]  sel_nib;
    logic        sel_dp;
    logic        frame_edge;

    // Only the 3 -> 0 step is a frame boundary; any other jump is just a
    // digit select.
    assign frame_edge = (ctl_p == 2'd3) && (ctl_q == 2'd0);

    // Digit i is a leading zero when it and every digit above it are zero.
    // A requested decimal point keeps the digit visible. Digit 0 always shows.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_blank
            if (gi == 0) begin : g_units
                assign blank_digit[gi] = 1'b0;
            end else begin : g_upper
                assign blank_digit[gi] = blank_lz
                                       && (disp_digits_reg[15:4*gi] == '0)
                                       && !disp_dp_reg[gi];
            end
        end
    endgenerate

    assign sel_nib = disp_digits_reg[{ctl_q, 2'b00} +: 4];
    assign sel_dp  = disp_dp_reg[ctl_q];

    function automatic logic [6:0] bcd_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    always_comb begin
        ssd_ctl_next = ~(4'b0001 << ctl_q);
        ssd_out_next = {bcd_seg(sel_nib), ~sel_dp};
        if (blink_en && tick_q) begin
            // Dark phase: everything off, scan/commit keep running.
            ssd_ctl_next = 4'b1111;
            ssd_out_next = 8'hFF;
        end else if (blank_digit[ctl_q]) begin
            ssd_out_next = 8'hFF;
        end else if (sel_nib > 4'd9) begin
            // Dash pattern replaces the digit entirely, dp included.
            ssd_out_next = INVALID_PAT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctl_q             <= 2'd0;
            ctl_p             <= 2'd0;
            tick_q            <= 1'b0;
            shadow_digits_reg <= '0;
            shadow_dp_reg     <= '0;
            disp_digits_reg   <= '0;
            disp_dp_reg       <= '0;
            pending_reg       <= 1'b0;
            commit_reg        <= 1'b0;
            ssd_ctl_reg       <= 4'b1111;
            ssd_out_reg       <= 8'hFF;
        end else begin
            ctl_q       <= clk_ctl;
            ctl_p       <= ctl_q;
            tick_q      <= tick_1hz;
            ssd_ctl_reg <= ssd_ctl_next;
            ssd_out_reg <= ssd_out_next;
            commit_reg  <= 1'b0;

            // Commit uses the shadow as it stood before this edge, so a load
            // landing in the boundary cycle is kept for the next frame.
            if (frame_edge && pending_reg) begin
                disp_digits_reg <= shadow_digits_reg;
                disp_dp_reg     <= shadow_dp_reg;
                commit_reg      <= 1'b1;
            end

            if (load) begin
                shadow_digits_reg <= digits_in;
                shadow_dp_reg     <= dp_in;
                pending_reg       <= 1'b1;
            end else if (frame_edge && pending_reg) begin
                pending_reg <= 1'b0;
            end
        end
    end

    assign ssd_ctl = ssd_ctl_reg;
    assign ssd_out = ssd_out_reg;
    assign pending = pending_reg;
    assign commit  = commit_reg;

endmodule
